par_to_serial_l3: RTL and testbench
===================================

Name: par_to_serial_L3

Overview:
- Final stage of the transmit path; sits directly downstream of the L2 2:1 byte mux.
- Consumes that stage's 8-bit byte plus valid bit and serializes it MSB-first on a single-bit line, eight bits per byte.
- Inserts the idle/comma character whenever no valid byte is present.
- Enforces a post-reset alignment preamble of idle characters before any data is passed.

Parameters:
- IDLE_CHAR, 8'hBC, character sent when valid_in=0 or during preamble
- MIN_IDLE, 4, number of whole idle characters forced after reset before data is accepted (1..15)

Ports:
- clk_32f  input  1  serial bit clock (8x the byte rate)
- reset_L  input  1  asynchronous active-low reset
- data_in  input  8  byte from L2 mux output (data_out1)
- valid_in  input  1  valid bit from L2 mux output (valid_bit_out1)
- data_out  output  1  serial bit stream, MSB first
- word_start  output  1  high during the bit period carrying bit 7 of each character
- active_out  output  1  high during all 8 bit periods of a character that carries real data
- ready_out  output  1  high once the preamble is complete (state RUN)

Behaviour:
- Clock/reset: one clock, clk_32f. reset_L is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values:
  - shift_reg = 8'h00, so data_out = 0
  - bit_cnt = 3'd7
  - idle_cnt = 0
  - state = INIT
  - word_start = 0, active_out = 0, ready_out = 0
- data_out is driven straight from shift_reg[7]; it is never derived combinationally from the inputs.
- Per rising edge, when bit_cnt == 7 (load edge):
  - bit_cnt <= 0
  - shift_reg <= loaded word
  - word_start <= 1
  - active_out <= 1 only if the loaded word is data
- Per rising edge, otherwise:
  - shift_reg <= {shift_reg[6:0], 1'b0}
  - bit_cnt <= bit_cnt + 1
  - word_start <= 0
  - active_out holds its value
- Loaded word:
  - state RUN and valid_in = 1: data_in
  - any other case: IDLE_CHAR
- Sampling: data_in and valid_in are sampled only on load edges and ignored at all other edges. Upstream holds them stable across each load edge (clk_4f phase-aligned to every 8th clk_32f edge).
- Latency: a byte sampled at load edge N has its bit 7 on data_out during cycle N+1 and its bit 0 during cycle N+8.
- The first load occurs on the first edge after reset release, so the idle stream begins with no dead byte. data_out is 0 only until that edge.
- FSM:
  - INIT: each load edge loads IDLE_CHAR and increments idle_cnt. When a load edge is taken with idle_cnt == MIN_IDLE-1, go to RUN and set ready_out <= 1 on that same edge.
  - RUN: stays in RUN until reset.
  - Net effect: exactly MIN_IDLE idle characters follow reset; the next load edge is the first at which valid data is accepted.
- Valid bytes presented during INIT are dropped. They are not queued, and upstream must gate on ready_out.
- In RUN, valid_in=0 at a load edge sends IDLE_CHAR with active_out=0. There is no limit on consecutive idles.
- Back-to-back valid bytes are sent with no gap bits; the byte period is exactly 8 clk_32f cycles.
- A data byte equal to IDLE_CHAR is sent unchanged with active_out=1. Receivers rely on active_out, not on the value.
- Reset mid-byte: the partial character is truncated immediately, outputs go to their reset values, and the full preamble restarts.
- bit_cnt wraps 7 -> 0 only through the load path. idle_cnt saturates at MIN_IDLE-1 (holds once in RUN).

Test Plan:
- Hold reset_L=0 for 5 cycles, then release with valid_in=0 -> data_out repeats 1,0,1,1,1,1,0,0 every 8 cycles. word_start pulses on cycles 1, 9, 17, ... after release. ready_out rises at the 4th load edge.
- valid_in=1, data_in=8'hA5 asserted from reset release -> first 4 characters are 8'hBC with active_out=0. The 5th character is 1,0,1,0,0,1,0,1 with active_out=1 for all 8 bits.
- In RUN, send 8'h00, 8'hFF, 8'h3C back-to-back with valid_in=1 -> 24 contiguous bits 00000000 11111111 00111100, no idle between them, active_out constantly 1.
- In RUN, alternate valid_in 1/0 per byte with data_in=8'hBC -> characters are identical on data_out. active_out toggles 1,0,1,0 per character.
- Change data_in/valid_in at non-load edges in mid-character -> the serial character in flight is unaffected; only the value present at the load edge appears.
- Assert reset_L low asynchronously at bit 3 of a data byte -> data_out, word_start, active_out and ready_out go to 0 without waiting for a clock edge. After release, 4 idle characters precede any data.

Source files
------------

// File: rtl/par_to_serial_l3.sv
// Final transmit stage: byte-to-serial converter, MSB first.
// Sends an idle preamble after reset, then data or idle chars.
module par_to_serial_l3 #(
    parameter logic [7:0]  IDLE_CHAR = 8'hBC,
    parameter int unsigned MIN_IDLE  = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       word_start,
    output logic       active_out,
    output logic       ready_out
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [3:0] IDLE_LAST = 4'(MIN_IDLE - 1);

    state_t     state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [3:0] idle_cnt;

    logic       load_edge;
    logic       take_data;
    logic [7:0] load_word;

    // bit_cnt resets to 7 so the first edge after reset loads
    assign load_edge = (bit_cnt == 3'd7);
    assign take_data = (state == RUN) && valid_in;
    assign load_word = take_data ? data_in : IDLE_CHAR;
    assign data_out  = shift_reg[7];

    // Shift register, bit counter and per-character flags
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd7;
            word_start <= 1'b0;
            active_out <= 1'b0;
        end else if (load_edge) begin
            shift_reg  <= load_word;
            bit_cnt    <= 3'd0;
            word_start <= 1'b1;
            active_out <= take_data;
        end else begin
            shift_reg  <= {shift_reg[6:0], 1'b0};
            bit_cnt    <= bit_cnt + 3'd1;
            word_start <= 1'b0;
        end
    end

    // Preamble FSM: count idle chars, then open the data path
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= INIT;
            idle_cnt  <= 4'd0;
            ready_out <= 1'b0;
        end else if (load_edge) begin
            unique case (state)
                INIT: begin
                    if (idle_cnt == IDLE_LAST) begin
                        state     <= RUN;
                        ready_out <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
                end
                RUN: begin
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_to_serial_l3.sv
// Self-checking bench for par_to_serial_l3.
// Reference model derives each bit from the edge count since reset.
module tb_par_to_serial_l3;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         MINI = 4;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out;
    logic       word_start;
    logic       active_out;
    logic       ready_out;

    int checks = 0;
    int errors = 0;

    int         e = 0;
    logic [7:0] m_w = 8'h00;
    logic       m_act = 1'b0;
    logic       m_rdy = 1'b0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] w;
        logic       act;
    } vec_t;

    vec_t tbl[10];

    par_to_serial_l3 #(
        .IDLE_CHAR(IDLE),
        .MIN_IDLE (MINI)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .word_start(word_start),
        .active_out(active_out),
        .ready_out (ready_out)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic cyc(input logic v, input logic [7:0] d, input bit cmp);
        int p;
        valid_in = v;
        data_in  = d;
        @(posedge clk_32f);
        p = e % 8;
        if (p == 0) begin
            m_act = ((e / 8) >= MINI) && v;
            m_w   = m_act ? d : IDLE;
            m_rdy = ((e / 8) >= MINI - 1);
        end
        e++;
        #1;
        if (cmp) begin
            chk("data_out", data_out, m_w[7-p]);
            chk("word_start", word_start, p == 0);
            chk("active_out", active_out, m_act);
            chk("ready_out", ready_out, m_rdy);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (5) @(posedge clk_32f);
        #1;
        chk("rst_data_out", data_out, 1'b0);
        chk("rst_word_start", word_start, 1'b0);
        chk("rst_active_out", active_out, 1'b0);
        chk("rst_ready_out", ready_out, 1'b0);
        reset_L = 1'b1;
        #1;
        chk("post_release_data_out", data_out, 1'b0);
        e     = 0;
        m_rdy = 1'b0;
        m_act = 1'b0;
    endtask

    task automatic align();
        while (e % 8 != 0) cyc(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] got;
        tbl[0] = '{1'b1, 8'h00, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
        tbl[2] = '{1'b1, 8'h3C, 8'h3C, 1'b1};
        tbl[3] = '{1'b1, 8'hBC, 8'hBC, 1'b1};
        tbl[4] = '{1'b0, 8'hBC, 8'hBC, 1'b0};
        tbl[5] = '{1'b1, 8'hBC, 8'hBC, 1'b1};
        tbl[6] = '{1'b0, 8'hBC, 8'hBC, 1'b0};
        tbl[7] = '{1'b0, 8'hA5, 8'hBC, 1'b0};
        tbl[8] = '{1'b1, 8'h5A, 8'h5A, 1'b1};
        tbl[9] = '{1'b1, 8'h81, 8'h81, 1'b1};

        // Idle stream and preamble after reset
        do_reset();
        repeat (6 * 8) cyc(1'b0, 8'h00, 1'b1);

        // Valid data from release: dropped until preamble completes
        do_reset();
        for (int c = 0; c < 6; c++) begin
            got = 8'h00;
            for (int b = 0; b < 8; b++) begin
                cyc(1'b1, 8'hA5, 1'b1);
                got = {got[6:0], data_out};
            end
            if (c == 3) chk("preamble_last_idle", got, IDLE);
            if (c == 4) chk("first_data_char", got, 8'hA5);
        end

        // Table-driven characters in RUN
        align();
        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 8; b++) begin
                cyc(tbl[i].v, tbl[i].d, 1'b1);
                chk("tbl_bit", data_out, tbl[i].w[7-b]);
                chk("tbl_act", active_out, tbl[i].act);
            end
        end

        // Inputs wiggling between load edges must not leak into the char
        align();
        got = 8'h00;
        cyc(1'b1, 8'h96, 1'b1);
        got = {got[6:0], data_out};
        for (int b = 1; b < 8; b++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            got = {got[6:0], data_out};
        end
        chk("midchar_byte", got, 8'h96);

        // Randomized traffic
        for (int c = 0; c < 40; c++) begin
            logic       rv;
            logic [7:0] rd;
            rv = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            cyc(rv, rd, 1'b1);
            for (int b = 1; b < 8; b++)
                cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        end

        // Asynchronous reset during bit 3 of a data byte
        align();
        repeat (5) cyc(1'b1, 8'hFF, 1'b1);
        chk("pre_async_data", data_out, 1'b1);
        chk("pre_async_ready", ready_out, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_data_out", data_out, 1'b0);
        chk("async_word_start", word_start, 1'b0);
        chk("async_active_out", active_out, 1'b0);
        chk("async_ready_out", ready_out, 1'b0);
        do_reset();
        repeat (6 * 8) cyc(1'b1, 8'h3C, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
